map_port_arbiter: RTL and testbench

Shares the single read port (port B) of the map colour-index BRAM between the minimap renderer and terrain queries from the two physics engines. Video gets the port unconditionally whenever it asks; the engines share the remaining cycles through a round-robin req/gnt handshake. The block converts engine (x, y) world coordinates to linear BRAM addresses and returns fixed-latency tagged read data.

---
 rtl/map_arb_pkg.sv | 31 +++
 rtl/map_xy_to_addr.sv | 27 ++
 rtl/map_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_map_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_arb_pkg.sv
`default_nettype none
// ============================================================================
// map_arb_pkg: map geometry, OOB colour and read-tag definitions shared by the
// BRAM port arbiter, the minimap renderer and the physics engines.
// Revision: 1.0
// ============================================================================
package map_arb_pkg;

  localparam int         MAP_WIDTH_C  = 320;
  localparam int         MAP_HEIGHT_C = 240;
  localparam logic [3:0] OOB_CODE_C   = 4'hF;
  localparam int         TAG_W        = 3;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VID  = 2'd1,
    SRC_P1   = 2'd2,
    SRC_P2   = 2'd3
  } src_e;

  typedef struct packed {
    src_e src;
    logic oob;
  } tag_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/map_xy_to_addr.sv
`default_nettype none
// ============================================================================
// map_xy_to_addr: world (x, y) to linear map BRAM address plus out-of-map flag.
// Revision: 1.0
// ============================================================================
module map_xy_to_addr #(
  parameter int MAP_WIDTH  = 320,
  parameter int MAP_HEIGHT = 240
) (
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  output logic [16:0] addr_o,
  output logic        oob_o
);

  localparam logic [10:0] WIDTH_L  = 11'(MAP_WIDTH);
  localparam logic [10:0] HEIGHT_L = 11'(MAP_HEIGHT);

  logic [16:0] y_ext;

  // y*320 as two shifted adds; result wraps to 17 bits for absurd y
  assign y_ext  = {7'd0, y_i};
  assign addr_o = (y_ext << 8) + (y_ext << 6) + {7'd0, x_i};
  assign oob_o  = ({1'b0, x_i} >= WIDTH_L) || ({1'b0, y_i} >= HEIGHT_L);

endmodule
`default_nettype wire

// File: rtl/map_port_arbiter.sv
`default_nettype none
// ============================================================================
// map_port_arbiter: shares map BRAM port B between the minimap (fixed priority)
// and two round-robin physics engines. Optional MAP_ARB_STATS_EN adds wait stats.
// Revision: 1.0
// ============================================================================
module map_port_arbiter
  import map_arb_pkg::*;
#(
  parameter int         RD_LAT     = 1,
  parameter int         MAP_WIDTH  = MAP_WIDTH_C,
  parameter int         MAP_HEIGHT = MAP_HEIGHT_C,
  parameter logic [3:0] OOB_CODE   = OOB_CODE_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_req,
  input  logic [16:0] vid_addr,
  output logic [3:0]  vid_data,
  input  logic        p1_req,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [3:0]  p1_rdata,
  input  logic        p2_req,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic        p2_gnt,
  output logic        p2_rvalid,
  output logic [3:0]  p2_rdata,
  output logic [16:0] bram_addr,
  input  logic [3:0]  bram_dout
`ifdef MAP_ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [7:0]  p1_max_wait,
  output logic [7:0]  p2_max_wait
`endif
);

  localparam int LAST = RD_LAT - 1;

  logic        ptr_q, ptr_d;   // 1: P2 was the last engine granted
  logic        gnt1, gnt2, eng_gnt;
  logic [9:0]  sel_x, sel_y;
  logic [16:0] xy_addr;
  logic        xy_oob;
  tag_t        tag_in;
  tag_t        tag_out;
  tag_t        tag_q [RD_LAT];
  logic [3:0]  p1_rdata_q, p1_rdata_d;
  logic [3:0]  p2_rdata_q, p2_rdata_d;

  always_comb begin
    gnt1    = rst & ~vid_req & p1_req & (~p2_req | ptr_q);
    gnt2    = rst & ~vid_req & p2_req & ~gnt1;
    eng_gnt = gnt1 | gnt2;
    ptr_d   = gnt1 ? 1'b0 : (gnt2 ? 1'b1 : ptr_q);
    sel_x   = gnt2 ? p2_x : p1_x;
    sel_y   = gnt2 ? p2_y : p1_y;
  end

  map_xy_to_addr #(
    .MAP_WIDTH (MAP_WIDTH),
    .MAP_HEIGHT(MAP_HEIGHT)
  ) u_xy_to_addr (
    .x_i   (sel_x),
    .y_i   (sel_y),
    .addr_o(xy_addr),
    .oob_o (xy_oob)
  );

  always_comb begin
    bram_addr  = '0;
    tag_in.src = SRC_NONE;
    tag_in.oob = 1'b0;
    if (rst && vid_req) begin
      bram_addr  = vid_addr;
      tag_in.src = SRC_VID;
    end else if (eng_gnt) begin
      bram_addr  = xy_oob ? 17'd0 : xy_addr;
      tag_in.src = gnt1 ? SRC_P1 : SRC_P2;
      tag_in.oob = xy_oob;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      ptr_q      <= 1'b1;
      p1_rdata_q <= '0;
      p2_rdata_q <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      ptr_q      <= ptr_d;
      p1_rdata_q <= p1_rdata_d;
      p2_rdata_q <= p2_rdata_d;
    end
  end

  // rdata follows bram_dout in the response cycle and holds otherwise
  always_comb begin
    tag_out    = tag_q[LAST];
    p1_rvalid  = (tag_out.src == SRC_P1);
    p2_rvalid  = (tag_out.src == SRC_P2);
    p1_rdata_d = p1_rdata_q;
    p2_rdata_d = p2_rdata_q;
    if (p1_rvalid) p1_rdata_d = tag_out.oob ? OOB_CODE : bram_dout;
    if (p2_rvalid) p2_rdata_d = tag_out.oob ? OOB_CODE : bram_dout;
    p1_rdata   = p1_rdata_d;
    p2_rdata   = p2_rdata_d;
  end

  assign vid_data = bram_dout;
  assign p1_gnt   = gnt1;
  assign p2_gnt   = gnt2;

`ifdef MAP_ARB_STATS_EN
  logic [7:0] p1_wait_q, p1_wait_d, p2_wait_q, p2_wait_d;
  logic [7:0] p1_max_q, p1_max_d, p2_max_q, p2_max_d;

  always_comb begin
    p1_wait_d = (p1_req && !gnt1) ? sat_inc8(p1_wait_q) : 8'd0;
    p2_wait_d = (p2_req && !gnt2) ? sat_inc8(p2_wait_q) : 8'd0;
    p1_max_d  = (p1_wait_d > p1_max_q) ? p1_wait_d : p1_max_q;
    p2_max_d  = (p2_wait_d > p2_max_q) ? p2_wait_d : p2_max_q;
    if (stats_clr) begin
      p1_wait_d = '0;
      p2_wait_d = '0;
      p1_max_d  = '0;
      p2_max_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_wait_q <= '0;
      p2_wait_q <= '0;
      p1_max_q  <= '0;
      p2_max_q  <= '0;
    end else begin
      p1_wait_q <= p1_wait_d;
      p2_wait_q <= p2_wait_d;
      p1_max_q  <= p1_max_d;
      p2_max_q  <= p2_max_d;
    end
  end

  assign p1_max_wait = p1_max_q;
  assign p2_max_wait = p2_max_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_map_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_map_port_arbiter: randomized self-checking bench against a behavioural
// BRAM + arbitration reference model. Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_map_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req;
  logic [16:0] vid_addr;
  logic [3:0]  vid_data;
  logic        p1_req, p2_req;
  logic [9:0]  p1_x, p1_y, p2_x, p2_y;
  logic        p1_gnt, p1_rvalid, p2_gnt, p2_rvalid;
  logic [3:0]  p1_rdata, p2_rdata;
  logic [16:0] bram_addr;
  logic [3:0]  bram_dout;
`ifdef MAP_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [7:0]  p1_max_wait, p2_max_wait;
`endif

  always #5 clk = ~clk;

  map_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_data (vid_data),
    .p1_req   (p1_req),
    .p1_x     (p1_x),
    .p1_y     (p1_y),
    .p1_gnt   (p1_gnt),
    .p1_rvalid(p1_rvalid),
    .p1_rdata (p1_rdata),
    .p2_req   (p2_req),
    .p2_x     (p2_x),
    .p2_y     (p2_y),
    .p2_gnt   (p2_gnt),
    .p2_rvalid(p2_rvalid),
    .p2_rdata (p2_rdata),
    .bram_addr(bram_addr),
    .bram_dout(bram_dout)
`ifdef MAP_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .p1_max_wait(p1_max_wait),
    .p2_max_wait(p2_max_wait)
`endif
  );

  // Behavioural BRAM port B, one cycle read latency
  logic [3:0] mem [131072];
  always @(posedge clk) bram_dout <= mem[bram_addr];

  int          checks = 0;
  int          failures = 0;
  bit          m_last_p2;
  bit          pv_vid, pv_p1, pv_p2;
  logic [3:0]  pv_data, h1, h2;
  bit          eg1, eg2, e_oob;
  logic [16:0] ea;
  logic [3:0]  er1, er2;

  function automatic bit in_map(input logic [9:0] x, input logic [9:0] y);
    return (int'(x) < 320) && (int'(y) < 240);
  endfunction

  function automatic logic [16:0] lin(input logic [9:0] x, input logic [9:0] y);
    return 17'(int'(y) * 320 + int'(x));
  endfunction

  task automatic model_reset();
    m_last_p2 = 1'b1;
    pv_vid = 1'b0; pv_p1 = 1'b0; pv_p2 = 1'b0;
    pv_data = '0; h1 = '0; h2 = '0;
  endtask

  task automatic set_in(input bit v, input logic [16:0] va,
                        input bit r1, input logic [9:0] x1, input logic [9:0] y1,
                        input bit r2, input logic [9:0] x2, input logic [9:0] y2);
    vid_req = v; vid_addr = va;
    p1_req = r1; p1_x = x1; p1_y = y1;
    p2_req = r2; p2_x = x2; p2_y = y2;
  endtask

  // Expected issue-cycle behaviour and expected response outputs for this cycle
  task automatic predict();
    eg1 = 1'b0; eg2 = 1'b0; e_oob = 1'b0; ea = '0;
    if (vid_req) begin
      ea = vid_addr;
    end else begin
      if (p1_req && p2_req) begin
        eg1 = m_last_p2;
        eg2 = !m_last_p2;
      end else begin
        eg1 = p1_req;
        eg2 = p2_req;
      end
      if (eg1) begin e_oob = !in_map(p1_x, p1_y); ea = e_oob ? 17'd0 : lin(p1_x, p1_y); end
      if (eg2) begin e_oob = !in_map(p2_x, p2_y); ea = e_oob ? 17'd0 : lin(p2_x, p2_y); end
    end
    er1 = pv_p1 ? pv_data : h1;
    er2 = pv_p2 ? pv_data : h2;
  endtask

  task automatic commit();
    h1 = er1; h2 = er2;
    pv_vid = vid_req; pv_p1 = eg1; pv_p2 = eg2;
    pv_data = e_oob ? 4'hF : mem[ea];
    if (eg1) m_last_p2 = 1'b0;
    if (eg2) m_last_p2 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b1, 17'd1234, 1'b1, 10'd1, 10'd1, 1'b1, 10'd2, 10'd2);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({p1_gnt, p2_gnt, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata, bram_addr} !== 29'd0) begin
      failures++;
      $display("FAIL reset_vals: got gnt=%b%b rv=%b%b rd=%h/%h addr=%0d, expected all zero",
               p1_gnt, p2_gnt, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata, bram_addr);
    end
    set_in(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single_p1();
    set_in(1'b0, '0, 1'b1, 10'd15, 10'd125, 1'b0, '0, '0);
    #1; predict();
    checks++;
    if (bram_addr !== 17'd40015 || p1_gnt !== 1'b1 || p2_gnt !== 1'b0) begin
      failures++;
      $display("FAIL single_issue: got addr=%0d gnt=%b%b, expected addr=40015 gnt=10", bram_addr, p1_gnt, p2_gnt);
    end
    commit();
    set_in(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    #1; predict();
    checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== mem[40015]) begin
      failures++;
      $display("FAIL single_resp: got rv=%b rd=%h, expected rv=1 rd=%h", p1_rvalid, p1_rdata, mem[40015]);
    end
    commit();
  endtask

  task automatic test_tie();
    logic [9:0] x1, y1, x2, y2;
    bit prev_g1;
    x1 = 10'($urandom_range(0, 319)); y1 = 10'($urandom_range(0, 239));
    x2 = 10'($urandom_range(0, 319)); y2 = 10'($urandom_range(0, 239));
    for (int c = 0; c < 24; c++) begin
      set_in(1'b0, '0, 1'b1, x1, y1, 1'b1, x2, y2);
      #1; predict();
      checks++;
      if ({p1_gnt, p2_gnt, bram_addr} !== {eg1, eg2, ea}) begin
        failures++;
        $display("FAIL tie_issue: got gnt=%b%b addr=%0d, expected gnt=%b%b addr=%0d", p1_gnt, p2_gnt, bram_addr, eg1, eg2, ea);
      end
      checks++;
      if ({p1_rvalid, p2_rvalid, p1_rdata, p2_rdata} !== {pv_p1, pv_p2, er1, er2}) begin
        failures++;
        $display("FAIL tie_resp: got rv=%b%b rd=%h/%h, expected rv=%b%b rd=%h/%h",
                 p1_rvalid, p2_rvalid, p1_rdata, p2_rdata, pv_p1, pv_p2, er1, er2);
      end
      if (c > 0) begin
        checks++;
        if (p1_gnt === prev_g1) begin
          failures++;
          $display("FAIL tie_alternate: got p1_gnt=%b twice, expected alternation", p1_gnt);
        end
      end
      prev_g1 = p1_gnt;
      if (eg1) begin x1 = 10'($urandom_range(0, 319)); y1 = 10'($urandom_range(0, 239)); end
      if (eg2) begin x2 = 10'($urandom_range(0, 319)); y2 = 10'($urandom_range(0, 239)); end
      commit();
    end
  endtask

  task automatic test_oob();
    set_in(1'b0, '0, 1'b1, 10'd320, 10'd10, 1'b0, '0, '0);
    #1; predict();
    checks++;
    if (p1_gnt !== 1'b1 || bram_addr !== 17'd0) begin
      failures++;
      $display("FAIL oob_x_issue: got gnt=%b addr=%0d, expected gnt=1 addr=0", p1_gnt, bram_addr);
    end
    commit();
    set_in(1'b0, '0, 1'b1, 10'd5, 10'd240, 1'b0, '0, '0);
    #1; predict();
    checks++;
    if (p1_gnt !== 1'b1 || bram_addr !== 17'd0 || p1_rvalid !== 1'b1 || p1_rdata !== 4'hF) begin
      failures++;
      $display("FAIL oob_y_issue: got gnt=%b addr=%0d rv=%b rd=%h, expected gnt=1 addr=0 rv=1 rd=f",
               p1_gnt, bram_addr, p1_rvalid, p1_rdata);
    end
    commit();
    set_in(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    #1; predict();
    checks++;
    if (p1_rvalid !== 1'b1 || p1_rdata !== 4'hF) begin
      failures++;
      $display("FAIL oob_y_resp: got rv=%b rd=%h, expected rv=1 rd=f", p1_rvalid, p1_rdata);
    end
    commit();
  endtask

  task automatic test_video_preempt();
    for (int c = 0; c <= 160; c++) begin
      set_in(c < 160, 17'($urandom_range(0, 131071)), 1'b0, '0, '0, 1'b1, 10'd7, 10'd30);
      #1; predict();
      checks++;
      if ({p1_gnt, p2_gnt, bram_addr} !== {1'b0, (c == 160), ea}) begin
        failures++;
        $display("FAIL vid_issue: cycle %0d got gnt=%b%b addr=%0d, expected gnt=0%b addr=%0d",
                 c, p1_gnt, p2_gnt, bram_addr, (c == 160), ea);
      end
      if (pv_vid) begin
        checks++;
        if (vid_data !== pv_data) begin
          failures++;
          $display("FAIL vid_data: cycle %0d got %h, expected %h", c, vid_data, pv_data);
        end
      end
      commit();
    end
`ifdef MAP_ARB_STATS_EN
    checks++;
    if (p2_max_wait !== 8'd160) begin
      failures++;
      $display("FAIL stats_p2_max: got %0d, expected 160", p2_max_wait);
    end
`endif
    set_in(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    #1; predict();
    checks++;
    if (p2_rvalid !== 1'b1 || p2_rdata !== mem[lin(10'd7, 10'd30)]) begin
      failures++;
      $display("FAIL vid_p2_resp: got rv=%b rd=%h, expected rv=1 rd=%h", p2_rvalid, p2_rdata, mem[lin(10'd7, 10'd30)]);
    end
    commit();
  endtask

  task automatic test_withdraw();
    for (int c = 0; c < 9; c++) begin
      set_in(c < 6, 17'($urandom_range(0, 131071)), 1'b0, '0, '0, c < 3, 10'd44, 10'd55);
      #1; predict();
      checks++;
      if ({p2_gnt, p2_rvalid} !== 2'b00) begin
        failures++;
        $display("FAIL withdraw: cycle %0d got gnt=%b rv=%b, expected gnt=0 rv=0", c, p2_gnt, p2_rvalid);
      end
      commit();
    end
  endtask

  task automatic test_random();
    bit n1, n2;
    n1 = 1'b1; n2 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (n1) set_in(vid_req, vid_addr, $urandom_range(0, 2) != 0, 10'($urandom_range(0, 340)),
                     10'($urandom_range(0, 260)), p2_req, p2_x, p2_y);
      else if (p1_req && $urandom_range(0, 15) == 0) p1_req = 1'b0;
      if (n2) begin
        p2_req = ($urandom_range(0, 2) != 0);
        p2_x = 10'($urandom_range(0, 340)); p2_y = 10'($urandom_range(0, 260));
      end else if (p2_req && $urandom_range(0, 15) == 0) p2_req = 1'b0;
      vid_req = ($urandom_range(0, 3) == 0);
      vid_addr = 17'($urandom_range(0, 131071));
      #1; predict();
      checks++;
      if ({p1_gnt, p2_gnt, bram_addr} !== {eg1, eg2, ea}) begin
        failures++;
        $display("FAIL rand_issue: cycle %0d got gnt=%b%b addr=%0d, expected gnt=%b%b addr=%0d",
                 c, p1_gnt, p2_gnt, bram_addr, eg1, eg2, ea);
      end
      checks++;
      if ({p1_rvalid, p2_rvalid, p1_rdata, p2_rdata} !== {pv_p1, pv_p2, er1, er2}) begin
        failures++;
        $display("FAIL rand_resp: cycle %0d got rv=%b%b rd=%h/%h, expected rv=%b%b rd=%h/%h",
                 c, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata, pv_p1, pv_p2, er1, er2);
      end
      if (pv_vid) begin
        checks++;
        if (vid_data !== pv_data) begin
          failures++;
          $display("FAIL rand_vid: cycle %0d got %h, expected %h", c, vid_data, pv_data);
        end
      end
      n1 = eg1 || !p1_req;
      n2 = eg2 || !p2_req;
      commit();
    end
  endtask

  task automatic test_reset_mid();
    set_in(1'b0, '0, 1'b1, 10'd100, 10'd50, 1'b0, '0, '0);
    #1; predict();
    checks++;
    if (p1_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_gnt: got %b, expected 1", p1_gnt);
    end
    commit();
    set_in(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    rst = 1'b0;
    #1;
    checks++;
    if ({p1_gnt, p2_gnt, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata, bram_addr} !== 29'd0) begin
      failures++;
      $display("FAIL rstmid_vals: got gnt=%b%b rv=%b%b rd=%h/%h addr=%0d, expected all zero",
               p1_gnt, p2_gnt, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata, bram_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      #1; predict();
      checks++;
      if ({p1_rvalid, p2_rvalid, p1_rdata, p2_rdata} !== 10'd0) begin
        failures++;
        $display("FAIL rstmid_after: cycle %0d got rv=%b%b rd=%h/%h, expected zero",
                 c, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata);
      end
      commit();
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 4'($urandom);
    model_reset();
    test_reset();
    test_single_p1();
    test_tie();
    test_oob();
    test_video_preempt();
    test_withdraw();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
